spi_reg_bridge: RTL and testbench
=================================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 8-bit registers (legal 4..128).
REQ-002 SHALL have parameter DEVICE_ID, default 8'hA5, read-only value of register 0.
REQ-003 SHALL have parameter CPOL, default 0, idle level of spi_sclk.
REQ-004 SHALL have parameter CPHA, default 0, SPI clock phase (0 = sample on leading edge, 1 = sample on trailing edge).
REQ-005 SHALL have port sys_clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port spi_sclk  input  1  SPI clock, asynchronous to sys_clk.
REQ-008 SHALL have port spi_cs_n  input  1  SPI chip select, active low.
REQ-009 SHALL have port spi_mosi  input  1  SPI data from host, MSB first.
REQ-010 SHALL have port spi_miso  output  1  SPI data to host, MSB first, registered.
REQ-011 SHALL have port status_in  input  8  live status value returned as register 1.
REQ-012 SHALL have port regs_flat  output  NUM_REGS*8  all register values; byte k occupies bits [8k+7:8k].
REQ-013 SHALL have port wr_stb  output  1  one-cycle pulse per completed register write.
REQ-014 SHALL have port wr_addr  output  7  address of the write flagged by wr_stb.
REQ-015 SHALL have port wr_data  output  8  data of the write flagged by wr_stb.
REQ-016 SHALL have port frame_abort  output  1  one-cycle pulse when CS rises with a partial byte.

Function
REQ-017 SHALL synchronise spi_sclk, spi_cs_n and spi_mosi through 2 flops each and detect edges on the synchronised sclk; spi_sclk frequency is at most sys_clk/8.
REQ-018 SHALL sample spi_mosi on the rising sclk edge when CPOL==CPHA, otherwise on the falling edge; spi_miso changes only on the opposite edge.
REQ-019 SHALL use a 4-state FSM: IDLE, CMD, WDATA, RDATA.
REQ-020 SHALL move IDLE->CMD on synchronised CS falling and reset the bit counter to 0.
REQ-021 SHALL decode the first byte as {rw, addr[6:0]}, with rw=1 meaning read; after its 8th sample it SHALL move CMD->RDATA if rw=1, else CMD->WDATA.
REQ-022 SHALL, in WDATA, write each completed byte to reg[addr] when 2<=addr<NUM_REGS.
REQ-023 SHALL, for each write in REQ-022, pulse wr_stb with wr_addr and wr_data one sys_clk after the 8th sample edge.
REQ-024 SHALL silently discard writes to addr 0, addr 1 and addr>=NUM_REGS, with no wr_stb.
REQ-025 SHALL, in RDATA, return DEVICE_ID for addr 0, status_in (sampled at byte load) for addr 1, reg[addr] for 2..NUM_REGS-1, and 8'h00 for addr>=NUM_REGS.
REQ-026 SHALL present read-data bit 7 on spi_miso before the first sample edge of each data byte, and bit n-1 before each later sample edge.
REQ-027 SHALL drive spi_miso to 0 throughout the command byte and in IDLE.
REQ-028 SHALL, after each data byte, increment addr (burst): NUM_REGS-1 wraps to 0; addr>=NUM_REGS increments modulo 128 and stays ignored.
REQ-029 SHALL, on synchronised CS rising in any state, return to IDLE; if the bit counter is nonzero it SHALL discard the partial byte and pulse frame_abort.
REQ-030 SHALL treat CS rising on the same sys_clk as an 8th sample edge as a completed byte first (write or strobe taken), then enter IDLE with no abort.

Reset
REQ-031 SHALL, on reset, set FSM=IDLE, addr=0, bit counter=0, spi_miso=0, wr_stb=0, wr_addr=0, wr_data=0, frame_abort=0.
REQ-032 SHALL, on reset, clear registers 2..NUM_REGS-1 to 8'h00 (regs_flat byte0=DEVICE_ID, byte1=status_in).
REQ-033 SHALL, on reset asserted mid-transaction, abandon the transaction with no write and no pulse; after release it SHALL wait in IDLE for the next CS falling edge.

Structure
REQ-034 SHALL take the FSM state encoding and the register indices (ID=0, STATUS=1, first RW=2) from shared package spi_reg_pkg.
REQ-035 SHALL place edge detection and shifting in one sub-module spi_slave_phy (bytes in/out, byte-done and cs-edge pulses); register decode stays in spi_reg_bridge.

Verification
REQ-036 SHALL verify, with mode 0 and NUM_REGS=16: read cmd 0x80 plus 1 dummy byte -> MISO returns 0xA5, no wr_stb.
REQ-037 SHALL verify: write cmd 0x02 plus bytes 0x11,0x22,0x33 -> three wr_stb (addr 2/3/4), regs_flat bytes 2..4 = 11/22/33.
REQ-038 SHALL verify: write burst at 0x0F with bytes 0xAA,0xBB -> reg15=AA, addr wraps to 0, 0xBB discarded, exactly one wr_stb.
REQ-039 SHALL verify: CS raised after 5 bits of a data byte to addr 5 -> frame_abort pulse, reg5 unchanged, next frame decodes normally.
REQ-040 SHALL verify: CPOL=1,CPHA=1 instance, status_in=0x3C, read cmd 0x81 -> MISO returns 0x3C.
REQ-041 SHALL verify: sys_rst_n asserted mid-burst write -> all outputs at reset values, registers 0, no wr_stb.

Source files
------------

// File: rtl/spi_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_reg_pkg : shared FSM encoding and fixed register indices               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  localparam logic [6:0] c_REG_ID       = 7'd0;
  localparam logic [6:0] c_REG_STATUS   = 7'd1;
  localparam logic [6:0] c_REG_FIRST_RW = 7'd2;

endpackage
`default_nettype wire

// File: rtl/spi_slave_phy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_slave_phy : SPI pin synchroniser, edge detect, byte shifter            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module spi_slave_phy #(
  parameter int CPOL = 0,
  parameter int CPHA = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       frame_abort
);

  localparam logic c_SCLK_IDLE   = (CPOL != 0);
  localparam logic c_SAMPLE_RISE = (CPOL == CPHA);

  logic [2:0] r_sclk_sync;
  logic [2:0] r_cs_sync;
  logic [1:0] r_mosi_sync;
  logic       r_in_frame;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_sr;
  logic [7:0] r_tx_sr;
  logic       r_miso;
  logic       r_abort;

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_take;
  logic w_shift_take;

  assign w_sclk_rise  = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall  = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_take       = r_in_frame & (c_SAMPLE_RISE ? w_sclk_rise : w_sclk_fall);
  assign w_shift_take = r_in_frame & (c_SAMPLE_RISE ? w_sclk_fall : w_sclk_rise);

  assign cs_fall     = r_cs_sync[2] & ~r_cs_sync[1];
  assign cs_rise     = ~r_cs_sync[2] & r_cs_sync[1];
  assign byte_done   = w_take & (r_bit_cnt == 3'd7);
  assign rx_byte     = {r_rx_sr, r_mosi_sync[1]};
  assign spi_miso    = r_miso;
  assign frame_abort = r_abort;

  // CS chain resets to "selected" so a CS held low across reset yields no
  // falling edge; the bridge then waits for a fresh select.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sclk_sync <= {3{c_SCLK_IDLE}};
      r_cs_sync   <= 3'b000;
      r_mosi_sync <= 2'b00;
      r_in_frame  <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_rx_sr     <= 7'd0;
      r_tx_sr     <= 8'd0;
      r_miso      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[1:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
      r_abort     <= cs_rise & r_in_frame & (r_bit_cnt != 3'd0) & ~byte_done;
      if (cs_fall || cs_rise) begin
        r_in_frame <= cs_fall;
        r_bit_cnt  <= 3'd0;
        r_tx_sr    <= 8'd0;
        r_miso     <= 1'b0;
      end else begin
        if (w_take) begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_rx_sr   <= {r_rx_sr[5:0], r_mosi_sync[1]};
        end
        if (tx_load) begin
          r_tx_sr <= tx_byte;
        end else if (w_shift_take) begin
          r_miso  <= r_tx_sr[7];
          r_tx_sr <= {r_tx_sr[6:0], 1'b0};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_reg_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_reg_bridge : SPI slave to 8-bit register file with burst addressing    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] DEVICE_ID = 8'hA5,
  parameter int         CPOL      = 0,
  parameter int         CPHA      = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic [7:0]            status_in,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_stb,
  output logic [6:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic                  frame_abort
);

  localparam int         c_AW   = $clog2(NUM_REGS);
  localparam logic [7:0] c_NUM  = 8'(NUM_REGS);
  localparam logic [6:0] c_LAST = 7'(NUM_REGS - 1);

  state_t     r_state;
  logic [6:0] r_addr;
  logic [7:0] r_regs [NUM_REGS];
  logic       r_wr_stb;
  logic [6:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_tx_load;
  logic [7:0] r_tx_byte;

  logic [7:0] w_rx_byte;
  logic       w_byte_done;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic [6:0] w_addr_next;
  logic       w_addr_writable;
  logic [6:0] w_rd_addr;
  logic [7:0] w_rd_data;

  spi_slave_phy #(
    .CPOL (CPOL),
    .CPHA (CPHA)
  ) u_phy (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .tx_load     (r_tx_load),
    .tx_byte     (r_tx_byte),
    .rx_byte     (w_rx_byte),
    .byte_done   (w_byte_done),
    .cs_fall     (w_cs_fall),
    .cs_rise     (w_cs_rise),
    .frame_abort (frame_abort)
  );

  // Out-of-range addresses keep counting modulo 128 and stay ignored.
  assign w_addr_next     = (r_addr == c_LAST) ? 7'd0 : r_addr + 7'd1;
  assign w_addr_writable = (r_addr >= c_REG_FIRST_RW) && ({1'b0, r_addr} < c_NUM);
  assign w_rd_addr       = (r_state == ST_CMD) ? w_rx_byte[6:0] : w_addr_next;

  always_comb begin
    w_rd_data = 8'h00;
    if (w_rd_addr == c_REG_ID) begin
      w_rd_data = DEVICE_ID;
    end else if (w_rd_addr == c_REG_STATUS) begin
      w_rd_data = status_in;
    end else if ({1'b0, w_rd_addr} < c_NUM) begin
      w_rd_data = r_regs[w_rd_addr[c_AW-1:0]];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= 7'd0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= 7'd0;
      r_wr_data <= 8'd0;
      r_tx_load <= 1'b0;
      r_tx_byte <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      r_wr_stb  <= 1'b0;
      r_tx_load <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (w_byte_done) begin
            r_addr  <= w_rx_byte[6:0];
            r_state <= w_rx_byte[7] ? ST_RDATA : ST_WDATA;
            if (w_rx_byte[7] && !w_cs_rise) begin
              r_tx_load <= 1'b1;
              r_tx_byte <= w_rd_data;
            end
          end
        end
        ST_WDATA: begin
          if (w_byte_done) begin
            r_addr <= w_addr_next;
            if (w_addr_writable) begin
              r_regs[r_addr[c_AW-1:0]] <= w_rx_byte;
              r_wr_stb                 <= 1'b1;
              r_wr_addr                <= r_addr;
              r_wr_data                <= w_rx_byte;
            end
          end
        end
        ST_RDATA: begin
          if (w_byte_done) begin
            r_addr <= w_addr_next;
            if (!w_cs_rise) begin
              r_tx_load <= 1'b1;
              r_tx_byte <= w_rd_data;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A byte completing on the deselect cycle is taken above before leaving.
      if (w_cs_rise) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign wr_stb  = r_wr_stb;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

  assign regs_flat[7:0]  = DEVICE_ID;
  assign regs_flat[15:8] = status_in;
  for (genvar k = 2; k < NUM_REGS; k++) begin : g_regs_flat
    assign regs_flat[8*k +: 8] = r_regs[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_reg_bridge : randomized SPI host against a behavioural register map |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_spi_reg_bridge;

  localparam int HALF = 8;

  logic         sys_clk   = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         sclk_a = 1'b0, cs_a = 1'b1, sclk_b = 1'b1, cs_b = 1'b1, mosi = 1'b0;
  logic [7:0]   status_a = 8'h00, status_b = 8'h00;
  logic         miso_a, miso_b, wr_stb_a, wr_stb_b, abort_a, abort_b;
  logic [127:0] regs_a, regs_b;
  logic [6:0]   wr_addr_a, wr_addr_b;
  logic [7:0]   wr_data_a, wr_data_b;

  always #5 sys_clk = ~sys_clk;

  spi_reg_bridge #(.NUM_REGS(16), .DEVICE_ID(8'hA5), .CPOL(0), .CPHA(0)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .spi_sclk(sclk_a), .spi_cs_n(cs_a),
    .spi_mosi(mosi), .spi_miso(miso_a), .status_in(status_a), .regs_flat(regs_a),
    .wr_stb(wr_stb_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .frame_abort(abort_a));

  spi_reg_bridge #(.NUM_REGS(16), .DEVICE_ID(8'hA5), .CPOL(1), .CPHA(1)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .spi_sclk(sclk_b), .spi_cs_n(cs_b),
    .spi_mosi(mosi), .spi_miso(miso_b), .status_in(status_b), .regs_flat(regs_b),
    .wr_stb(wr_stb_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .frame_abort(abort_b));

  int checks = 0, errors = 0;
  int stb_a_cnt = 0, stb_b_cnt = 0, abort_a_cnt = 0, abort_b_cnt = 0;
  logic [7:0]  m_regs [16];
  logic [14:0] exp_q [$];
  logic [14:0] exp_e;
  logic [7:0]  got_rd [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a);
    if (a == 7'd0)      return 8'hA5;
    else if (a == 7'd1) return status_a;
    else if (a < 7'd16) return m_regs[a[3:0]];
    else                return 8'h00;
  endfunction

  function automatic logic [127:0] m_flat();
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[8*k +: 8] = m_read(7'(k));
    return f;
  endfunction

  // Every strobe must match the next write the model predicted.
  always @(negedge sys_clk) begin
    if (wr_stb_a) begin
      stb_a_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr_stb: got addr %0h data %0h expected no strobe", wr_addr_a, wr_data_a);
      end else begin
        exp_e = exp_q.pop_front();
        chk("wr_stb_addr_data", {wr_addr_a, wr_data_a}, exp_e);
      end
    end
    if (abort_a)  abort_a_cnt++;
    if (wr_stb_b) stb_b_cnt++;
    if (abort_b)  abort_b_cnt++;
    chk("regs_fixed_bytes", regs_a[15:0], {status_a, 8'hA5});
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // inst 0: mode 0 host; inst 1: mode 3 host.
  task automatic spi_bits(input int inst, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (inst == 0) begin
        mosi = tx[7-i];
        wait_cyc(HALF);
        sclk_a = 1'b1;
        rx[7-i] = miso_a;
        wait_cyc(HALF);
        sclk_a = 1'b0;
      end else begin
        sclk_b = 1'b0;
        mosi = tx[7-i];
        wait_cyc(HALF);
        sclk_b = 1'b1;
        rx[7-i] = miso_b;
        wait_cyc(HALF);
      end
    end
  endtask

  task automatic run_frame_a(input logic [7:0] cmd, input int nbytes, input logic [31:0] data, input int last_bits);
    logic [6:0] addr;
    logic [7:0] exp_rd [4];
    logic [7:0] d, rx;
    int ab0, nb, full;
    addr = cmd[6:0];
    ab0  = abort_a_cnt;
    full = (last_bits < 8) ? nbytes - 1 : nbytes;
    for (int k = 0; k < 4; k++) exp_rd[k] = 8'h00;
    for (int k = 0; k < full; k++) begin
      d = data[31-8*k -: 8];
      if (cmd[7]) begin
        exp_rd[k] = m_read(addr);
      end else if (addr >= 7'd2 && addr < 7'd16) begin
        m_regs[addr[3:0]] = d;
        exp_q.push_back({addr, d});
      end
      addr = (addr == 7'd15) ? 7'd0 : addr + 7'd1;
    end
    cs_a = 1'b0;
    wait_cyc(6);
    spi_bits(0, cmd, 8, rx);
    chk("cmd_byte_miso", rx, 8'h00);
    for (int k = 0; k < nbytes; k++) begin
      nb = (k == nbytes - 1) ? last_bits : 8;
      d  = data[31-8*k -: 8];
      spi_bits(0, d, nb, rx);
      got_rd[k] = rx;
      if (nb == 8 && cmd[7]) chk("read_byte", rx, exp_rd[k]);
    end
    wait_cyc(HALF);
    cs_a = 1'b1;
    wait_cyc(12);
    chk("frame_abort_count", abort_a_cnt - ab0, (last_bits < 8) ? 1 : 0);
    chk("pending_writes", exp_q.size(), 0);
    chk("regs_flat", regs_a, m_flat());
    chk("miso_idle", miso_a, 1'b0);
  endtask

  task automatic frame_b(input logic [7:0] cmd, input logic [7:0] d, output logic [7:0] rx);
    logic [7:0] tmp;
    cs_b = 1'b0;
    wait_cyc(6);
    spi_bits(1, cmd, 8, tmp);
    chk("b_cmd_byte_miso", tmp, 8'h00);
    spi_bits(1, d, 8, rx);
    wait_cyc(HALF);
    cs_b = 1'b1;
    wait_cyc(12);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx;
    int s0;
    for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;

    wait_cyc(4);
    chk("reset_miso", miso_a, 1'b0);
    chk("reset_wr_stb", wr_stb_a, 1'b0);
    chk("reset_wr_addr", wr_addr_a, 7'd0);
    chk("reset_wr_data", wr_data_a, 8'd0);
    chk("reset_abort", abort_a, 1'b0);
    chk("reset_regs", regs_a, {112'd0, status_a, 8'hA5});
    sys_rst_n = 1'b1;
    wait_cyc(10);

    s0 = stb_a_cnt;
    run_frame_a(8'h80, 1, 32'h0, 8);
    chk("id_read", got_rd[0], 8'hA5);
    chk("id_read_no_stb", stb_a_cnt - s0, 0);

    s0 = stb_a_cnt;
    run_frame_a(8'h02, 3, 32'h11223300, 8);
    chk("burst_stb_count", stb_a_cnt - s0, 3);
    chk("burst_reg2", regs_a[23:16], 8'h11);
    chk("burst_reg3", regs_a[31:24], 8'h22);
    chk("burst_reg4", regs_a[39:32], 8'h33);

    s0 = stb_a_cnt;
    run_frame_a(8'h0F, 2, 32'hAABB0000, 8);
    chk("wrap_stb_count", stb_a_cnt - s0, 1);
    chk("wrap_reg15", regs_a[127:120], 8'hAA);
    chk("wrap_reg0", regs_a[7:0], 8'hA5);

    s0 = abort_a_cnt;
    run_frame_a(8'h05, 1, 32'hFF000000, 5);
    chk("abort_pulse", abort_a_cnt - s0, 1);
    chk("abort_reg5", regs_a[47:40], 8'h00);
    run_frame_a(8'h82, 2, 32'h0, 8);
    chk("after_abort_rd2", got_rd[0], 8'h11);
    chk("after_abort_rd3", got_rd[1], 8'h22);

    run_frame_a(8'h8F, 2, 32'h0, 8);
    chk("rd_wrap_15", got_rd[0], 8'hAA);
    chk("rd_wrap_0", got_rd[1], 8'hA5);
    run_frame_a(8'h90, 1, 32'h0, 8);
    chk("rd_out_of_range", got_rd[0], 8'h00);

    for (int f = 0; f < 30; f++) begin
      logic [6:0] a;
      logic [7:0] cmd;
      int nb, lb;
      status_a = 8'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 17));
      cmd = {1'($urandom_range(0, 1)), a};
      nb  = $urandom_range(1, 3);
      lb  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
      run_frame_a(cmd, nb, $urandom, lb);
    end

    status_b = 8'h3C;
    frame_b(8'h81, 8'h00, rx);
    chk("b_status_read", rx, 8'h3C);
    frame_b(8'h80, 8'h00, rx);
    chk("b_id_read", rx, 8'hA5);
    s0 = stb_b_cnt;
    frame_b(8'h03, 8'h5A, rx);
    chk("b_write_stb", stb_b_cnt - s0, 1);
    chk("b_reg3", regs_b[31:24], 8'h5A);
    frame_b(8'h83, 8'h00, rx);
    chk("b_readback", rx, 8'h5A);
    chk("b_no_abort", abort_b_cnt, 0);

    // Reset in the middle of a write burst.
    status_a = 8'h00;
    s0 = stb_a_cnt;
    exp_q.push_back({7'd4, 8'h77});
    cs_a = 1'b0;
    wait_cyc(6);
    spi_bits(0, 8'h04, 8, rx);
    spi_bits(0, 8'h77, 8, rx);
    spi_bits(0, 8'h88, 4, rx);
    wait_cyc(2);
    chk("pre_reset_stb", stb_a_cnt - s0, 1);
    sys_rst_n = 1'b0;
    for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;
    wait_cyc(3);
    chk("midrst_miso", miso_a, 1'b0);
    chk("midrst_wr_stb", wr_stb_a, 1'b0);
    chk("midrst_wr_addr", wr_addr_a, 7'd0);
    chk("midrst_wr_data", wr_data_a, 8'd0);
    chk("midrst_abort", abort_a, 1'b0);
    chk("midrst_regs", regs_a, {112'd0, 8'h00, 8'hA5});
    sys_rst_n = 1'b1;
    wait_cyc(10);
    s0 = abort_a_cnt;
    spi_bits(0, 8'h02, 8, rx);
    spi_bits(0, 8'h55, 8, rx);
    wait_cyc(HALF);
    cs_a = 1'b1;
    wait_cyc(12);
    chk("postrst_no_abort", abort_a_cnt - s0, 0);
    chk("postrst_pending", exp_q.size(), 0);
    chk("postrst_regs", regs_a, m_flat());
    run_frame_a(8'h02, 1, 32'h99000000, 8);
    run_frame_a(8'h82, 1, 32'h0, 8);
    chk("postrst_readback", got_rd[0], 8'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
